// File: rtl/seg2hex_scan.sv
// seg2hex_scan: loopback monitor for a multiplexed 8-digit seven-segment bus; rebuilds the hex word on display.
// Optional inactivity timeout that drops `valid`: define SEG2HEX_TIMEOUT_EN.
module seg2hex_scan #(
  parameter int STABLE_CNT = 4,
  parameter int TIMEOUT    = 1048576
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  seg,
  input  logic [7:0]  an,
  output logic [31:0] hex,
  output logic [7:0]  dp,
  output logic [7:0]  err,
  output logic        valid,
  output logic        frame_done
);

  localparam logic [7:0] STABLE_V = 8'(STABLE_CNT);

  if (STABLE_CNT < 2 || STABLE_CNT > 255 || TIMEOUT < 1) begin : g_param_check
    $error("seg2hex_scan: STABLE_CNT must be 2..255 and TIMEOUT >= 1");
  end

  // Returns {illegal, nibble}; an unknown glyph decodes to nibble 0.
  function automatic logic [4:0] decode_glyph(input logic [6:0] g);
    case (g)
      7'b1111110: decode_glyph = 5'h00;
      7'b0110000: decode_glyph = 5'h01;
      7'b1101101: decode_glyph = 5'h02;
      7'b1111001: decode_glyph = 5'h03;
      7'b0110011: decode_glyph = 5'h04;
      7'b1011011: decode_glyph = 5'h05;
      7'b1011111: decode_glyph = 5'h06;
      7'b1110000: decode_glyph = 5'h07;
      7'b1111111: decode_glyph = 5'h08;
      7'b1111011: decode_glyph = 5'h09;
      7'b1110111: decode_glyph = 5'h0A;
      7'b0011111: decode_glyph = 5'h0B;
      7'b1001110: decode_glyph = 5'h0C;
      7'b0111101: decode_glyph = 5'h0D;
      7'b1001111: decode_glyph = 5'h0E;
      7'b1000111: decode_glyph = 5'h0F;
      default:    decode_glyph = 5'h10;
    endcase
  endfunction

  logic [7:0]  seg_q, an_q;
  logic [15:0] prev_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        acc_q, acc_d;
  logic [31:0] nib_q, nib_d;
  logic [7:0]  sdp_q, sdp_d, serr_q, serr_d, seen_q, seen_d;
  logic [31:0] hex_q, hex_d;
  logic [7:0]  dp_q, dp_d, err_q, err_d;
  logic        valid_q, valid_d, frame_done_q, frame_done_d;

  logic [2:0]  sel_idx_s;
  logic        legal_s, same_s, accept_s;
  logic [4:0]  dec_s;

`ifdef SEG2HEX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_V = TW'(TIMEOUT);
  logic [TW-1:0] tmr_q, tmr_d;
`endif

  assign legal_s = $onehot(~an_q);
  assign same_s  = ({an_q, seg_q} == prev_q);
  assign dec_s   = decode_glyph(seg_q[7:1]);

  // Digit index of the single low select; only meaningful when legal_s is set.
  always_comb begin
    case (an_q)
      8'b11111110: sel_idx_s = 3'd0;
      8'b11111101: sel_idx_s = 3'd1;
      8'b11111011: sel_idx_s = 3'd2;
      8'b11110111: sel_idx_s = 3'd3;
      8'b11101111: sel_idx_s = 3'd4;
      8'b11011111: sel_idx_s = 3'd5;
      8'b10111111: sel_idx_s = 3'd6;
      8'b01111111: sel_idx_s = 3'd7;
      default:     sel_idx_s = 3'd0;
    endcase
  end

  // Dwell counting, digit acceptance, frame completion and optional timeout.
  always_comb begin
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    nib_d        = nib_q;
    sdp_d        = sdp_q;
    serr_d       = serr_q;
    seen_d       = seen_q;
    hex_d        = hex_q;
    dp_d         = dp_q;
    err_d        = err_q;
    valid_d      = valid_q;
    frame_done_d = 1'b0;
    accept_s     = 1'b0;
`ifdef SEG2HEX_TIMEOUT_EN
    tmr_d        = tmr_q;
`endif

    if (same_s && legal_s) begin
      if (cnt_q < STABLE_V) begin
        cnt_d = cnt_q + 8'd1;
      end else begin
        cnt_d = cnt_q;
      end
      accept_s = (cnt_d == STABLE_V) && !acc_q;
    end else begin
      cnt_d = legal_s ? 8'd1 : 8'd0;
      acc_d = 1'b0;
    end

    if (accept_s) begin
      acc_d                            = 1'b1;
      nib_d[{sel_idx_s, 2'b00} +: 4]   = dec_s[3:0];
      serr_d[sel_idx_s]                = dec_s[4];
      sdp_d[sel_idx_s]                 = seg_q[0];
      seen_d[sel_idx_s]                = 1'b1;
    end else begin
      acc_d = acc_d;
    end

    // The completing digit is merged straight into the published word.
    if (accept_s && (seen_d == 8'hFF)) begin
      hex_d        = nib_d;
      dp_d         = sdp_d;
      err_d        = serr_d;
      valid_d      = 1'b1;
      frame_done_d = 1'b1;
      seen_d       = 8'h00;
    end else begin
      frame_done_d = 1'b0;
    end

`ifdef SEG2HEX_TIMEOUT_EN
    if (accept_s) begin
      tmr_d = '0;
    end else if (tmr_q == TO_V - TW'(1)) begin
      tmr_d   = TO_V;
      valid_d = 1'b0;
      seen_d  = 8'h00;
    end else if (tmr_q != TO_V) begin
      tmr_d = tmr_q + TW'(1);
    end else begin
      tmr_d = tmr_q;
    end
`endif
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q        <= 8'h00;
      an_q         <= 8'h00;
      prev_q       <= 16'h0000;
      cnt_q        <= 8'h00;
      acc_q        <= 1'b0;
      nib_q        <= 32'h0000_0000;
      sdp_q        <= 8'h00;
      serr_q       <= 8'h00;
      seen_q       <= 8'h00;
      hex_q        <= 32'h0000_0000;
      dp_q         <= 8'h00;
      err_q        <= 8'h00;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef SEG2HEX_TIMEOUT_EN
      tmr_q        <= '0;
`endif
    end else begin
      seg_q        <= seg;
      an_q         <= an;
      prev_q       <= {an_q, seg_q};
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      nib_q        <= nib_d;
      sdp_q        <= sdp_d;
      serr_q       <= serr_d;
      seen_q       <= seen_d;
      hex_q        <= hex_d;
      dp_q         <= dp_d;
      err_q        <= err_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
`ifdef SEG2HEX_TIMEOUT_EN
      tmr_q        <= tmr_d;
`endif
    end
  end

  assign hex        = hex_q;
  assign dp         = dp_q;
  assign err        = err_q;
  assign valid      = valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/seg2hex_scan.md
# seg2hex_scan

Captures the time-multiplexed, high-active 8-digit seven-segment bus (segment lines plus active-low digit selects) driven by the display scanner. Decodes each digit pattern back to its hex nibble and assembles a 32-bit word. Each pattern must be stable for a programmable number of cycles before it is accepted. Sits on the display pins as a loopback/self-check monitor, so the bench and on-board logic can read back what the display is showing.

## Interface
- STABLE_CNT, 4: consecutive identical samples (2..255) required before a digit is accepted.
- TIMEOUT, 1048576: cycles without any digit acceptance before `valid` drops (only with the macro in Configuration).
- clk  input  1  single system clock; all state is on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low; clears all state.
- seg  input  8  segment lines, high active; bit7=a … bit1=g, bit0=dp.
- an  input  8  digit selects, active-low; bit i low selects digit i (nibble hex[4i+3:4i]).
- hex  output  32  last complete captured word.
- dp  output  8  decimal-point state per digit from the last complete frame.
- err  output  8  per-digit flag: accepted pattern was not a legal hex glyph (nibble forced to 0).
- valid  output  1  at least one complete frame captured and not timed out.
- frame_done  output  1  one-cycle pulse when `hex`/`dp`/`err` update.

## Operation
- Input stage: `seg`/`an` are registered once (s_seg, s_an). All decisions use the registered values.
- Glyph table on s_seg[7:1]:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
  - Any other value is illegal. dp (s_seg[0]) is carried separately and never affects the decode.
- Dwell tracking:
  - A selection is legal only when exactly one bit of s_an is 0. All-ones (blanking) and multiple-low are not legal selections.
  - When {s_an,s_seg} equals the previous sample and the selection is legal, the dwell counter increments, saturating at STABLE_CNT.
  - Otherwise the counter loads 1 if the selection is legal, else 0, and the per-dwell "accepted" flag clears.
- Acceptance: when the counter reaches STABLE_CNT and accepted=0, digit d is accepted:
  - shadow nibble[d] gets the decoded value, or 0 if illegal.
  - shadow err[d] is set if the glyph is illegal, shadow dp[d] gets s_seg[0], and seen[d] is set.
  - accepted is set, so a long dwell accepts only once.
- Frame completion:
  - On the edge where an acceptance makes seen == 8'hFF, hex/dp/err load the shadow values with the new digit merged.
  - On that same edge: valid=1, frame_done=1, seen clears.
  - Shadow contents persist; digits are overwritten individually.
- Re-acceptance of a digit already seen in the current frame overwrites its shadow nibble. seen is unchanged.
- States are implicit (IDLE: counter 0; DWELL: counting; HELD: accepted, waiting for change). No other FSM.

## Timing
- Reset values: hex=0, dp=0, err=0, valid=0, frame_done=0; seen, shadow, counter, accepted all 0.
- Latency: a pattern presented on `seg`/`an` from cycle t is accepted on the edge ending cycle t+STABLE_CNT (1 input register + STABLE_CNT matching samples).
- Frame outputs update on that same acceptance edge. frame_done is high for exactly the following cycle.
- Any change of `an` or `seg` for one cycle restarts the dwell. A glitch shorter than STABLE_CNT cycles is never accepted.
- Reset asserted mid-frame discards partial shadow/seen immediately. The first frame after reset needs all 8 digits again.
- Simultaneous timeout expiry and frame completion: completion wins, valid=1, timer restarts.

## Configuration
- SEG2HEX_TIMEOUT_EN defined:
  - A counter of cycles since the last acceptance runs; it clears on every acceptance.
  - When it reaches TIMEOUT, valid goes to 0 and seen clears. hex/dp/err hold their values.
  - valid returns to 1 only on the next complete frame.
- SEG2HEX_TIMEOUT_EN not defined: no timer. valid stays 1 from the first complete frame until reset.

## Test plan
- Scan 8'h12345678 (digit i held 8 cycles, an=~(1<<i), seg per glyph table, dp=0), STABLE_CNT=4 -> after the 8th digit: hex=32'h12345678, err=0, valid=1, one frame_done pulse.
- Scan digits 0..7 with glyphs A,b,C,d,E,F,0,9 and dp set on digit 3 -> hex=32'h90FEDCBA, dp=8'h08.
- Digit 2 shows seg=8'b00000010 (illegal), others legal "0" -> frame completes, hex nibble2=0, err=8'h04.
- A 3-cycle glitch of seg=8'hFE inserted mid-dwell on digit 5 showing '1' -> digit 5 still captured as 1; no acceptance of 8; dwell restarts after the glitch.
- an=8'hFF or 8'hFC held 100 cycles -> no acceptance, no frame_done. Assert rst_n low after 5 digits -> all outputs 0 immediately; next full scan is required for valid.
- With SEG2HEX_TIMEOUT_EN, TIMEOUT=64: complete one frame, then hold an=8'hFF -> valid falls exactly 64 cycles after the last acceptance, hex unchanged.
